// File: rtl/ffchk_pkg.sv
// ffchk_pkg: FSM state encoding and saturating-increment helper shared by the flip-flop cell checkers
package ffchk_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    // Callers pass their counter width; the result is truncated back by the caller.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/ffchk_delay_line.sv
// ffchk_delay_line: LATENCY-deep {d, valid} shift register with synchronous flush and async reset
module ffchk_delay_line #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic flush,
    input  logic d,
    output logic head_d,
    output logic head_valid
);

    logic [LATENCY-1:0] d_sr;
    logic [LATENCY-1:0] v_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_sr <= '0;
            v_sr <= '0;
        end else if (flush) begin
            v_sr <= '0;
        end else if (shift) begin
            d_sr <= (d_sr << 1) | LATENCY'(d);
            v_sr <= (v_sr << 1) | LATENCY'(1'b1);
        end
    end

    assign head_d     = d_sr[LATENCY-1];
    assign head_valid = v_sr[LATENCY-1];

endmodule

// File: rtl/ff_response_checker.sv
// ff_response_checker: compares a flip-flop's Q/Qbar against delayed D and keeps failure statistics
module ff_response_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             enable,
    input  logic             clear,
    input  logic             d_in,
    input  logic             q_in,
    input  logic             qbar_in,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] compl_count,
    output logic             mismatch,
    output logic             compl_err,
    output logic             sticky_fail,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_valid
);

    import ffchk_pkg::*;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       head_d;
    logic       head_valid;
    logic       active;
    logic       do_check;
    logic       mm_now;
    logic       ce_now;
    logic       fail_now;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(64'(v), CNT_W));
    endfunction

    ffchk_delay_line #(.LATENCY(LATENCY)) u_delay (
        .clk        (clk_in),
        .rst        (rst_in),
        .shift      (enable),
        .flush      (!enable),
        .d          (d_in),
        .head_d     (head_d),
        .head_valid (head_valid)
    );

    // A valid head only exists once LATENCY consecutive enabled samples have been shifted in,
    // so stale data after an enable drop can never be compared.
    always_comb begin
        active    = enable && (state != IDLE);
        do_check  = active && head_valid;
        mm_now    = do_check && (q_in !== head_d);
        ce_now    = active && (q_in === qbar_in);
        fail_now  = mm_now || ce_now;
        state_nxt = !enable ? IDLE : (state == IDLE ? FILL : (head_valid ? CHECK : FILL));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state            <= IDLE;
            check_count      <= '0;
            error_count      <= '0;
            compl_count      <= '0;
            mismatch         <= 1'b0;
            compl_err        <= 1'b0;
            sticky_fail      <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            mismatch  <= mm_now;
            compl_err <= ce_now;
            if (clear) begin
                check_count      <= '0;
                error_count      <= '0;
                compl_count      <= '0;
                sticky_fail      <= 1'b0;
                first_fail_idx   <= '0;
                first_fail_valid <= 1'b0;
            end else begin
                if (do_check) check_count <= inc(check_count);
                if (mm_now) error_count <= inc(error_count);
                if (ce_now) compl_count <= inc(compl_count);
                if (fail_now) sticky_fail <= 1'b1;
                if (fail_now && !first_fail_valid) begin
                    first_fail_idx   <= check_count;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ff_response_checker.sv
// tb_ff_response_checker: randomized and directed check of two checker instances against a history-based model
module tb_ff_response_checker;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clear = 1'b0, d = 1'b0;
    logic q[2], qb[2];
    logic [15:0] cc1, ec1, xc1, ffi1;
    logic [3:0]  cc3, ec3, xc3, ffi3;
    logic mm1, ce1, st1, ffv1, mm3, ce3, st3, ffv3;

    int lat[2] = '{1, 3};
    int wid[2] = '{16, 4};
    int run[2], cc[2], ec[2], xc[2], ffi[2];
    bit st[2], ffv[2], emm[2], ece[2];
    logic hist[2][8];
    int checks = 0, failures = 0;
    int hold;

    always #5 clk = ~clk;

    ff_response_checker #(.LATENCY(1), .CNT_W(16)) dut1 (
        .clk_in(clk), .rst_in(rst), .enable(enable), .clear(clear), .d_in(d),
        .q_in(q[0]), .qbar_in(qb[0]), .check_count(cc1), .error_count(ec1),
        .compl_count(xc1), .mismatch(mm1), .compl_err(ce1), .sticky_fail(st1),
        .first_fail_idx(ffi1), .first_fail_valid(ffv1)
    );

    ff_response_checker #(.LATENCY(3), .CNT_W(4)) dut3 (
        .clk_in(clk), .rst_in(rst), .enable(enable), .clear(clear), .d_in(d),
        .q_in(q[1]), .qbar_in(qb[1]), .check_count(cc3), .error_count(ec3),
        .compl_count(xc3), .mismatch(mm3), .compl_err(ce3), .sticky_fail(st3),
        .first_fail_idx(ffi3), .first_fail_valid(ffv3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        return (v + 1 > (1 << w) - 1) ? (1 << w) - 1 : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; cc[i] = 0; ec[i] = 0; xc[i] = 0; ffi[i] = 0;
            st[i] = 0; ffv[i] = 0; emm[i] = 0; ece[i] = 0;
        end
    endtask

    // run[i] = consecutive enabled edges seen; a check needs the last lat[i] edges enabled
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit act, hv, mm, ce;
            act = enable && run[i] >= 1;
            hv  = enable && run[i] >= lat[i];
            mm  = hv && (q[i] !== hist[i][lat[i]-1]);
            ce  = act && (q[i] === qb[i]);
            if (clear) begin
                cc[i] = 0; ec[i] = 0; xc[i] = 0; ffi[i] = 0; st[i] = 0; ffv[i] = 0;
            end else begin
                if ((mm || ce) && !ffv[i]) begin ffi[i] = cc[i]; ffv[i] = 1; end
                if (hv) cc[i] = sat(cc[i], wid[i]);
                if (mm) ec[i] = sat(ec[i], wid[i]);
                if (ce) xc[i] = sat(xc[i], wid[i]);
                if (mm || ce) st[i] = 1;
            end
            emm[i] = mm;
            ece[i] = ce;
            run[i] = enable ? run[i] + 1 : 0;
            if (enable) begin
                for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = d;
            end
        end
    endtask

    task automatic compare(input string ph);
        for (int i = 0; i < 2; i++) begin
            string t;
            t = $sformatf("%s/L%0d", ph, lat[i]);
            chk({t, ".check_count"}, i ? 32'(cc3) : 32'(cc1), cc[i]);
            chk({t, ".error_count"}, i ? 32'(ec3) : 32'(ec1), ec[i]);
            chk({t, ".compl_count"}, i ? 32'(xc3) : 32'(xc1), xc[i]);
            chk({t, ".first_fail_idx"}, i ? 32'(ffi3) : 32'(ffi1), ffi[i]);
            chk({t, ".mismatch"}, i ? 32'(mm3) : 32'(mm1), 32'(emm[i]));
            chk({t, ".compl_err"}, i ? 32'(ce3) : 32'(ce1), 32'(ece[i]));
            chk({t, ".sticky_fail"}, i ? 32'(st3) : 32'(st1), 32'(st[i]));
            chk({t, ".first_fail_valid"}, i ? 32'(ffv3) : 32'(ffv1), 32'(ffv[i]));
        end
    endtask

    // dv < 0 selects a random D; err/cv/xq are per-instance fault masks (bit0 = L1, bit1 = L3)
    task automatic drive(input bit e, input bit c, input int dv, input bit [1:0] err,
                         input bit [1:0] cv, input bit [1:0] xq, input string ph);
        @(negedge clk);
        enable = e;
        clear  = c;
        d      = (dv < 0) ? 1'($urandom_range(0, 1)) : 1'(dv);
        for (int i = 0; i < 2; i++) begin
            q[i]  = xq[i] ? 1'bx : (hist[i][lat[i]-1] ^ err[i]);
            qb[i] = cv[i] ? q[i] : ~q[i];
        end
        @(posedge clk);
        model_edge();
        #1 compare(ph);
    endtask

    // Called 1 time unit after a posedge; finishes before the following negedge.
    task automatic async_reset(input string ph);
        #1 rst = 1'b1;
        #1 model_reset();
        compare(ph);
        chk({ph, ".immediate_cc"}, 32'(cc1), 32'd0);
        #1 rst = 1'b0;
    endtask

    initial begin
        int pattern[7] = '{0, 1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 2; i++) begin
            q[i] = 1'b0; qb[i] = 1'b1;
            for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
        end
        model_reset();
        #6 compare("reset");
        #3 rst = 1'b0;

        for (int k = 0; k < 7; k++) drive(1, 0, pattern[k], 2'b00, 2'b00, 2'b00, "ideal");
        drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "ideal");
        chk("ideal.L1_checks", 32'(cc1), 32'd7);
        chk("ideal.L1_errors", 32'(ec1), 32'd0);
        chk("ideal.L1_compl", 32'(xc1), 32'd0);
        chk("ideal.L1_sticky", 32'(st1), 32'd0);
        chk("ideal.L3_checks", 32'(cc3), 32'd5);

        drive(1, 1, -1, 2'b00, 2'b00, 2'b00, "inject_clr");
        for (int k = 0; k < 3; k++) drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "inject_pre");
        drive(1, 0, -1, 2'b01, 2'b00, 2'b00, "inject");
        chk("inject.mismatch", 32'(mm1), 32'd1);
        chk("inject.errors", 32'(ec1), 32'd1);
        chk("inject.ffi", 32'(ffi1), 32'd3);
        chk("inject.ffv", 32'(ffv1), 32'd1);
        chk("inject.sticky", 32'(st1), 32'd1);
        drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "inject_post");
        chk("inject.one_pulse", 32'(mm1), 32'd0);

        drive(1, 1, -1, 2'b00, 2'b00, 2'b00, "compl_clr");
        drive(1, 0, -1, 2'b00, 2'b11, 2'b00, "compl");
        chk("compl.first_pulse", 32'(ce1), 32'd1);
        drive(1, 0, -1, 2'b00, 2'b11, 2'b00, "compl");
        chk("compl.second_pulse", 32'(ce1), 32'd1);
        chk("compl.count", 32'(xc1), 32'd2);
        chk("compl.ffi", 32'(ffi1), 32'd0);
        drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "compl_post");
        chk("compl.pulse_end", 32'(ce1), 32'd0);

        hold = int'(cc3);
        drive(0, 0, -1, 2'b00, 2'b00, 2'b00, "drop");
        for (int k = 0; k < 3; k++) drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "refill");
        chk("refill.L3_no_check", 32'(cc3), 32'(hold));
        drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "refill_first");
        chk("refill.L3_first_check", 32'(cc3), 32'(hold + 1));
        chk("refill.L3_no_mismatch", 32'(mm3), 32'd0);

        drive(1, 1, -1, 2'b00, 2'b00, 2'b00, "sat_clr");
        for (int k = 0; k < 20; k++) drive(1, 0, -1, 2'b10, 2'b00, 2'b00, "sat");
        chk("sat.L3_errors", 32'(ec3), 32'd15);
        chk("sat.L3_checks", 32'(cc3), 32'd15);

        drive(1, 1, -1, 2'b11, 2'b00, 2'b00, "clr_mm");
        chk("clr_mm.L1_errors", 32'(ec1), 32'd0);
        chk("clr_mm.L3_errors", 32'(ec3), 32'd0);
        chk("clr_mm.pulse", 32'(mm1), 32'd1);

        drive(1, 0, -1, 2'b11, 2'b00, 2'b00, "pre_rst");
        drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "pre_rst");
        async_reset("async_rst");
        for (int k = 0; k < 4; k++) drive(1, 0, -1, 2'b00, 2'b00, 2'b00, "resume");

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, -1,
                  2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0),
                  2'($urandom_range(0, 7) == 0 ? $urandom_range(0, 3) : 0),
                  2'($urandom_range(0, 19) == 0 ? $urandom_range(0, 3) : 0), "random");
            if ($urandom_range(0, 99) == 0) async_reset("random_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ff_response_checker.md
Name: ff_response_checker

Overview:
- Synthesizable response checker for the flip-flop cells under test. It is the receiving end of the stimulus path: the bench drives D, and this block samples the DUT's Q/Qbar and compares them against an internal delayed-D reference model.
- Counts checks, mismatches and Q/Qbar complement violations, and captures the index of the first failure.
- Sits beside each DUT instance in the flip-flop test harness.

Parameters:
- LATENCY, 1, clock cycles from D being sampled to the matching Q being valid; legal range 1..8.
- CNT_W, 16, width of all counters and the failure index.

Ports:
- clk_in  input  1  checker clock; same clock as the DUT; rising-edge sampling.
- rst_in  input  1  asynchronous, active-high reset.
- enable  input  1  run checker; low returns the block to IDLE.
- clear  input  1  synchronous clear of counters and sticky state; no effect on the FSM.
- d_in  input  1  stimulus D, as driven to the DUT.
- q_in  input  1  DUT Q.
- qbar_in  input  1  DUT Qbar.
- check_count  output  CNT_W  number of comparisons performed.
- error_count  output  CNT_W  number of Q mismatches.
- compl_count  output  CNT_W  number of cycles with q_in == qbar_in.
- mismatch  output  1  one-cycle pulse on a Q mismatch.
- compl_err  output  1  one-cycle pulse on a complement violation.
- sticky_fail  output  1  set on any mismatch or complement violation; cleared only by reset or clear.
- first_fail_idx  output  CNT_W  value of check_count at the first failure.
- first_fail_valid  output  1  first_fail_idx holds a captured value.

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, expectation pipeline and its valid bits all 0.
- FSM states: IDLE, FILL, CHECK.
  - IDLE -> FILL when enable=1.
  - FILL -> CHECK after the LATENCY-th valid sample reaches the pipeline head.
  - Any state -> IDLE when enable=0. The pipeline valid bits are cleared in the same edge.
- Pipeline:
  - LATENCY-deep shift register of {d, valid}.
  - While enable=1, it shifts every rising edge and loads d_in with valid=1.
  - The expected value is the pipeline head.
- Comparison: in CHECK, on each edge where head valid=1:
  - check_count increments.
  - If q_in differs from the head d, then mismatch=1 for that cycle and error_count increments.
  - Comparison is case-inequality, so X/Z on q_in counts as a mismatch.
- Complement check:
  - In FILL or CHECK, if q_in equals qbar_in (including both X), compl_err pulses and compl_count increments.
  - This check does not depend on head valid.
- Event ordering:
  - mismatch and compl_err are registered, asserted the cycle after the sampling edge, and each lasts exactly one cycle per event.
  - Both may assert in the same cycle.
- First fail:
  - On the first mismatch or compl_err event with first_fail_valid=0, capture first_fail_idx as the pre-increment check_count and set first_fail_valid.
  - Later failures do not overwrite the captured value.
- Counters saturate at all-ones and never wrap. check_count continues to saturate while errors still count independently.
- clear:
  - Zeroes check_count, error_count, compl_count, sticky_fail, first_fail_idx and first_fail_valid.
  - clear takes priority over an increment in the same cycle.
  - It does not touch the FSM or the pipeline.
- Reset mid-operation: asynchronously forces the full reset state. Sampling resumes on the first edge after rst_in falls.
- Re-entering FILL after enable drops: the pipeline must refill. No comparison is made against stale data.

Decomposition:
- Shared package ffchk_pkg holds:
  - the FSM state encoding (IDLE=2'd0, FILL=2'd1, CHECK=2'd2);
  - a saturating-increment function parameterized by width.
- One sub-module is natural: ffchk_delay_line, the LATENCY-deep {d, valid} shift register with synchronous flush and async reset. It is reused by other cell checkers.
- Counters and FSM stay in the top module.

Test Plan:
- Ideal DUT model: LATENCY=1, enable=1, D pattern 0,1,0,1,1,0,1, Q = D delayed by one cycle, Qbar=~Q. Required after 7 checks: check_count=7, error_count=0, compl_count=0, sticky_fail=0.
- Single injected error: same setup, but force q_in wrong on the 4th check. Required: mismatch pulses once, error_count=1, first_fail_idx=3, first_fail_valid=1, sticky_fail=1.
- Complement violation: hold q_in=qbar_in=1 for 2 cycles in CHECK. Required: compl_count=2, compl_err high for 2 cycles, first_fail_idx latched at the first of the two.
- LATENCY=3: the first 3 enabled edges are FILL with no checks (check_count=0). The first check occurs on the 4th edge and compares q_in to the 1st sampled D.
- Enable drop mid-run: drop enable for 1 cycle, then restore it. Required: FSM passes IDLE -> FILL, check_count does not increment for LATENCY edges, and no spurious mismatch occurs.
- Reset and clear priority:
  - Assert rst_in asynchronously mid-CHECK: all outputs are 0 immediately.
  - With CNT_W=4, drive 20 errors: error_count saturates at 15.
  - Assert clear on a mismatch cycle: counters read 0 next cycle.
